shared_ram_arbiter: RTL
=======================

# shared_ram_arbiter

Round-robin arbiter that shares the single port of one `RAM_2` instance between `N_PORTS` requesters, for example processor cores or a DMA loader. It sits between the requesters and the memory, and forwards one access per cycle to the RAM's registered input stage. It returns a per-port completion pulse aligned to the RAM's one-cycle read latency. A bounded lock mechanism allows short atomic bursts without permanent starvation of the other ports.

## Interface
Parameters:
- `N_PORTS`, 4: number of requesters (2..8).
- `WIDTH`, 12: data width; must match the RAM.
- `DEPTH`, 256: RAM depth.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: address width.
- `MAX_LOCK`, 8: maximum consecutive grants to one locked port before a forced rotation (≥1).

Ports:
- `clk` in 1: single clock; all state changes on the posedge.
- `rst` in 1: reset, synchronous and active-high.
- `req` in `[N_PORTS]`: access request; held until granted.
- `wrEn` in `[N_PORTS]`: 1 = write, 0 = read; qualified by `req`.
- `lock` in `[N_PORTS]`: requests that priority be kept after this grant.
- `addr` in `[N_PORTS][ADDR_WIDTH]`: per-port address.
- `dataIn` in `[N_PORTS][WIDTH]`: per-port write data.
- `gnt` out `[N_PORTS]`: one-hot grant; combinational, same cycle as the accepted `req`.
- `ack` out `[N_PORTS]`: one-hot completion pulse, exactly one cycle after `gnt`.
- `rdData` out `[WIDTH]`: read data, valid while `ack` is high for a read.
- `ram_wrEn` out 1: to RAM `wrEn`.
- `ram_addr` out `[ADDR_WIDTH]`: to RAM `addr`.
- `ram_dataIn` out `[WIDTH]`: to RAM `dataIn`.
- `ram_dataOut` in `[WIDTH]`: from RAM `dataOut`.

## Operation
- **Pointer `ptr`:** at most one grant per cycle. The winner is the first asserted `req` at or after `ptr`, searching upward modulo `N_PORTS`. No request means no grant.
- **Winner drive:** the winner's `wrEn`, `addr` and `dataIn` drive the `ram_*` outputs in the grant cycle.
- **Idle drive:** with no grant, `ram_wrEn` = 0, and `ram_addr`/`ram_dataIn` hold the last granted values.
- **Pointer update, unlocked:** after a grant to port k with `lock[k]` = 0, `ptr` becomes (k+1) mod `N_PORTS` and `lock_cnt` becomes 0.
- **Pointer update, locked:** after a grant to port k with `lock[k]` = 1, `ptr` becomes k and `lock_cnt` increments.
- **Forced rotation:** when the grant takes `lock_cnt` to `MAX_LOCK`, `ptr` becomes (k+1) mod `N_PORTS` and `lock_cnt` becomes 0, regardless of `lock`.
- **No-grant cycle:** `ptr` and `lock_cnt` are unchanged.
- **Ack pipeline:** registers `ack_q` (one-hot of the last grant) and `rd_q` (the last grant was a read). `ack` = `ack_q`. `rdData` = `ram_dataOut`, passed through combinationally; it is meaningful only when `ack` is high and `rd_q` = 1.
- **Write completion:** a write's `ack` means the RAM commits it at the end of that ack cycle.
- **Read-after-write:** a read granted the cycle after a write to the same address returns the new data. This follows from the RAM's registered input stage; no forwarding logic is required.
- **Request withdrawal:** a requester that drops `req` before being granted is legal and generates nothing.

## Timing
- **Reset values:**
  - `ptr` = 0, `lock_cnt` = 0, `ack_q` = 0, `rd_q` = 0.
  - `gnt` = 0 and `ram_wrEn` = 0 while `rst` is high, even if `req` is high. This guarantees the RAM's internal write-enable register is cleared on the first posedge in reset.
  - `ram_addr` = 0 and `ram_dataIn` = 0.
- **Reset mid-operation:** an outstanding `ack` due in the cycle after `rst` is suppressed.
- **Latency:** `req` to `gnt` is 0 cycles when uncontended; `gnt` to `ack` is 1 cycle. Throughput is one access per cycle, and back-to-back grants to the same or different ports are allowed.
- **Worst-case wait:** `(N_PORTS-1)·MAX_LOCK` cycles with all ports locked, or `N_PORTS-1` cycles with none locked.

## Structure
- **Package `mem_arb_pkg`:** holds the `N_PORTS` and `MAX_LOCK` defaults, a `port_idx_t` typedef of width `$clog2(N_PORTS)`, and a `lock_cnt_t` typedef of width `$clog2(MAX_LOCK+1)`.
- **Sub-module `rr_pick`:** combinational round-robin picker; inputs `req` and `ptr`, outputs a one-hot `gnt` and an index.
- **`shared_ram_arbiter`:** owns `ptr`, `lock_cnt`, the ack pipeline and the data muxes. `RAM_2` is instantiated alongside it at the top level, not inside it.

## Test plan
- **Reset:** hold `rst` with all `req` = 1. Then `gnt` = 0 and `ram_wrEn` = 0. On the first cycle after release, `gnt` = 0001.
- **Write then read:** port 2 writes 0xABC to addr 0x10 in cycle t, and port 0 reads 0x10 in cycle t+1. Then `ack[2]` in t+1, `ack[0]` in t+2, and `rdData` = 0xABC in t+2.
- **Full contention:** all four ports hold `req` with no lock. Grants go 0,1,2,3,0,… in consecutive cycles, with each `ack` one cycle behind.
- **Lock:** port 1 holds `req` and `lock` while port 3 requests, `MAX_LOCK` = 8. Port 1 gets 8 consecutive grants, port 3 is granted on the 9th cycle, then port 1 resumes.
- **Reset during traffic:** assert `rst` in the cycle after a read grant. `ack` stays 0 and `ptr` returns to 0.
- **Withdrawal:** port 3 raises `req` for one cycle while port 0 wins, then drops it. Port 3 gets no `gnt` or `ack`, and no spurious RAM write occurs.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the round-robin RAM port arbiter.
// Default port count, lock bound and the index/counter types derived from them.
package mem_arb_pkg;

  localparam int N_PORTS_DEF  = 4;
  localparam int MAX_LOCK_DEF = 8;

  typedef logic [$clog2(N_PORTS_DEF)-1:0]    port_idx_t;
  typedef logic [$clog2(MAX_LOCK_DEF+1)-1:0] lock_cnt_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// searching upward modulo N_PORTS.
module rr_pick #(
  parameter  int N_PORTS = 4,
  localparam int IDX_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int w_pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    w_pos = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_pos = int'(ptr) + i;
      if (w_pos >= N_PORTS) w_pos = w_pos - N_PORTS;
      if (!any && req[w_pos]) begin
        any        = 1'b1;
        gnt[w_pos] = 1'b1;
        idx        = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between N_PORTS requesters,
// with a bounded lock for short atomic bursts and a one-cycle ack pipeline.
module shared_ram_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_PORTS    = N_PORTS_DEF,
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int MAX_LOCK   = MAX_LOCK_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_PORTS-1:0]                  req,
  input  logic [N_PORTS-1:0]                  wrEn,
  input  logic [N_PORTS-1:0]                  lock,
  input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]  addr,
  input  logic [N_PORTS-1:0][WIDTH-1:0]       dataIn,
  output logic [N_PORTS-1:0]                  gnt,
  output logic [N_PORTS-1:0]                  ack,
  output logic [WIDTH-1:0]                    rdData,
  output logic                                ram_wrEn,
  output logic [ADDR_WIDTH-1:0]               ram_addr,
  output logic [WIDTH-1:0]                    ram_dataIn,
  input  logic [WIDTH-1:0]                    ram_dataOut
);

  localparam int IDX_W = $clog2(N_PORTS);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  logic [N_PORTS-1:0]    w_req;
  logic [N_PORTS-1:0]    w_gnt;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_any;
  logic [IDX_W-1:0]      w_ptr_inc;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_keep;

  logic [IDX_W-1:0]      r_ptr;
  logic [CNT_W-1:0]      r_lock_cnt;
  logic [N_PORTS-1:0]    r_ack_q;
  logic                  r_rd_q;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [WIDTH-1:0]      r_data_hold;

  // Requests are masked in reset so the RAM's write-enable register clears.
  assign w_req = rst ? '0 : req;

  rr_pick #(.N_PORTS(N_PORTS)) u_pick (
    .req (w_req),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

  assign w_ptr_inc = (w_idx == IDX_W'(N_PORTS - 1)) ? '0 : w_idx + 1'b1;
  assign w_cnt_inc = r_lock_cnt + 1'b1;
  assign w_keep    = lock[w_idx] && (w_cnt_inc != CNT_W'(MAX_LOCK));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_lock_cnt  <= '0;
      r_ack_q     <= '0;
      r_rd_q      <= 1'b0;
      r_addr_hold <= '0;
      r_data_hold <= '0;
    end else begin
      r_ack_q <= w_gnt;
      r_rd_q  <= w_any & ~wrEn[w_idx];
      if (w_any) begin
        r_addr_hold <= addr[w_idx];
        r_data_hold <= dataIn[w_idx];
        if (w_keep) begin
          r_ptr      <= w_idx;
          r_lock_cnt <= w_cnt_inc;
        end else begin
          r_ptr      <= w_ptr_inc;
          r_lock_cnt <= '0;
        end
      end
    end
  end

  assign gnt        = w_gnt;
  assign ack        = rst ? '0 : r_ack_q;
  assign rdData     = ram_dataOut;
  assign ram_wrEn   = w_any & wrEn[w_idx];
  assign ram_addr   = w_any ? addr[w_idx]   : r_addr_hold;
  assign ram_dataIn = w_any ? dataIn[w_idx] : r_data_hold;

endmodule
